// File: rtl/ddr_rd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_req_arbiter
// Description : Round-robin arbiter that shares the single MIG read-command
//               port among NUM_PORTS DDR loaders (0 weights, 1 ifmap,
//               2 bias/instr). Every issued command's port ID is queued in
//               an in-order tag FIFO so that returned read data can be
//               steered back to the loader that asked for it, one registered
//               cycle after the MIG presents it.
// Ports       : clk, reset          clock / synchronous active-high reset
//               req, req_adr        per-port level request and address
//               req_rdy             per-port grant (command issued on req&rdy)
//               mig_rdy, mig_cmd_*  MIG read-command interface
//               mig_rd_valid/data   MIG read-data return (in command order)
//               rsp_valid/data      per-port return strobe, shared data bus
//               outstanding         commands issued but not yet returned
//               err_orphan          sticky: data returned with no tag queued
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_req_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADR_W     = 32,
    parameter int DATA_W    = 512,
    parameter int TAG_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*ADR_W-1:0]     req_adr,
    output logic [NUM_PORTS-1:0]           req_rdy,
    input  logic                           mig_rdy,
    output logic                           mig_cmd_en,
    output logic [ADR_W-1:0]               mig_cmd_adr,
    input  logic                           mig_rd_valid,
    input  logic [DATA_W-1:0]              mig_rd_data,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [$clog2(TAG_DEPTH):0]     outstanding,
    output logic                           err_orphan
);

    localparam int c_ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_PTR_W = $clog2(TAG_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(TAG_DEPTH);
    localparam logic [c_ID_W-1:0]  c_LAST_INIT = c_ID_W'(NUM_PORTS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_ID_W-1:0]  r_last_gnt;
    logic [c_ID_W-1:0]  r_tag_mem [TAG_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_err_orphan;

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic [ADR_W-1:0]     w_port_adr [NUM_PORTS];
    logic [c_ID_W-1:0]    w_win;
    logic [c_ID_W-1:0]    w_head;
    logic [NUM_PORTS-1:0] w_win_onehot;
    logic [NUM_PORTS-1:0] w_head_onehot;
    logic [ADR_W-1:0]     w_win_adr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_can_issue;
    logic                 w_push;
    logic                 w_pop;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack_adr
        assign w_port_adr[gi] = req_adr[gi*ADR_W +: ADR_W];
    end

    // Search last_gnt+1, +2, ... with wrap. Walking the offsets from the
    // farthest to the nearest lets the nearest requesting port overwrite
    // the result, which yields the round-robin winner without a priority
    // encoder chain.
    always_comb begin
        logic [c_ID_W-1:0] v_idx;
        w_win = r_last_gnt;
        v_idx = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            v_idx = c_ID_W'((int'(r_last_gnt) + k) % NUM_PORTS);
            if (req[v_idx]) begin
                w_win = v_idx;
            end
        end
    end

    assign w_head  = r_tag_mem[r_rd_ptr];
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_win_onehot  = '0;
        w_head_onehot = '0;
        w_win_adr     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_win == c_ID_W'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_adr       = w_port_adr[i];
            end
            if (w_head == c_ID_W'(i)) begin
                w_head_onehot[i] = 1'b1;
            end
        end
    end

    // Grant depends only on req, mig_rdy and internal state, never on a
    // loader's own enable, so there is no combinational loop back through
    // the requesters.
    assign w_can_issue = mig_rdy && !w_full && (|req);
    assign w_push      = w_can_issue;
    assign w_pop       = mig_rd_valid && !w_empty;

    assign req_rdy     = w_can_issue ? w_win_onehot : '0;
    assign mig_cmd_en  = w_can_issue;
    assign mig_cmd_adr = w_can_issue ? w_win_adr : '0;

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= c_LAST_INIT;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_last_gnt <= w_win;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Tag storage carries no reset: entries are only read behind a valid
    // count, and reset clears the count and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_win;
        end
    end

    // Return path: one registered cycle from mig_rd_valid to rsp_valid.
    // Data is only captured on a routed return so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop ? w_head_onehot : '0;
            if (w_pop) begin
                r_rsp_data <= mig_rd_data;
            end
            if (mig_rd_valid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign outstanding = r_count;
    assign err_orphan  = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_rd_req_arbiter
// Description : Self-checking bench for ddr_rd_req_arbiter (3 ports, 4-deep
//               tag FIFO). A queue-based reference model predicts grants,
//               command addresses, routed responses, outstanding count and
//               the orphan flag every cycle; directed scenarios are followed
//               by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_req_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_adr;
    logic [N-1:0]      req_rdy;
    logic              mig_rdy;
    logic              mig_cmd_en;
    logic [AW-1:0]     mig_cmd_adr;
    logic              mig_rd_valid;
    logic [DW-1:0]     mig_rd_data;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [2:0]        outstanding;
    logic              err_orphan;

    ddr_rd_req_arbiter #(
        .NUM_PORTS (N),
        .ADR_W     (AW),
        .DATA_W    (DW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_adr      (req_adr),
        .req_rdy      (req_rdy),
        .mig_rdy      (mig_rdy),
        .mig_cmd_en   (mig_cmd_en),
        .mig_cmd_adr  (mig_cmd_adr),
        .mig_rd_valid (mig_rd_valid),
        .mig_rd_data  (mig_rd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .outstanding  (outstanding),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_last;
    int          m_q[$];
    logic [N-1:0] m_rsp_valid;
    logic [DW-1:0] m_rsp_data;
    logic        m_err;
    bit          m_known;   // false until the first reset edge

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int exp_win();
        for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last      = N - 1;
        m_rsp_valid = '0;
        m_rsp_data  = '0;
        m_err       = 1'b0;
        m_known     = 1'b1;
    endtask

    // One clock: check grant outputs mid-cycle, advance model on the edge,
    // then check registered outputs just after the edge.
    task automatic cyc();
        int w;
        bit can;
        int id;
        logic [N-1:0] e_rdy;
        logic [AW-1:0] e_adr;
        @(negedge clk);
        w     = exp_win();
        can   = mig_rdy && (m_q.size() < TD) && (w >= 0);
        e_rdy = '0;
        e_adr = '0;
        if (can) begin
            e_rdy[w] = 1'b1;
            e_adr    = req_adr[w*AW +: AW];
        end
        if (m_known) begin
            check("req_rdy", DW'(req_rdy), DW'(e_rdy));
            check("cmd_en", DW'(mig_cmd_en), DW'(can));
            check("cmd_adr", DW'(mig_cmd_adr), DW'(e_adr));
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_rsp_valid = '0;
            if (mig_rd_valid) begin
                if (m_q.size() > 0) begin
                    id = m_q.pop_front();
                    m_rsp_valid[id] = 1'b1;
                    m_rsp_data = mig_rd_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (can) begin
                m_q.push_back(w);
                m_last = w;
            end
        end
        #1;
        if (m_known) begin
            check("rsp_valid", DW'(rsp_valid), DW'(m_rsp_valid));
            check("rsp_data", rsp_data, m_rsp_data);
            check("outstanding", DW'(outstanding), DW'(m_q.size()));
            check("err_orphan", DW'(err_orphan), DW'(m_err));
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Return words back-to-back until the model has nothing outstanding.
    task automatic drain();
        for (int i = 0; i < TD && m_q.size() > 0; i++) begin
            mig_rd_valid = 1'b1;
            mig_rd_data  = rnd_word();
            cyc();
        end
        mig_rd_valid = 1'b0;
    endtask

    initial begin
        m_known      = 1'b0;
        m_last       = N - 1;
        m_rsp_valid  = '0;
        m_rsp_data   = '0;
        m_err        = 1'b0;
        reset        = 1'b1;
        req          = '0;
        req_adr      = '0;
        mig_rdy      = 1'b0;
        mig_rd_valid = 1'b0;
        mig_rd_data  = '0;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Lone requester on port 0, four consecutive commands, slow returns.
        mig_rdy = 1'b1;
        req     = 3'b001;
        for (int i = 0; i < 4; i++) begin
            req_adr[0 +: AW] = 32'h100 + i;
            cyc();
        end
        req = '0;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            idle(10);
            mig_rd_valid = 1'b1;
            mig_rd_data  = rnd_word();
            cyc();
            mig_rd_valid = 1'b0;
        end
        idle(2);

        // All ports after reset: grant order 0,1,2,0, back-to-back returns.
        do_reset();
        req_adr = {32'h2000_0000, 32'h1000_0000, 32'h0000_0040};
        req     = 3'b111;
        idle(4);
        req = '0;
        drain();
        idle(1);

        // Full tag FIFO: issues stop, one return re-opens exactly one slot.
        req = 3'b111;
        idle(6);
        mig_rd_valid = 1'b1;
        mig_rd_data  = rnd_word();
        cyc();
        mig_rd_valid = 1'b0;
        idle(3);
        req = '0;
        drain();

        // MIG back-pressure holds the round-robin pointer.
        req     = 3'b111;
        mig_rdy = 1'b0;
        idle(3);
        mig_rdy = 1'b1;
        idle(3);
        req = '0;
        drain();

        // Orphan return: flag sets and sticks.
        mig_rd_valid = 1'b1;
        mig_rd_data  = rnd_word();
        cyc();
        mig_rd_valid = 1'b0;
        idle(3);

        // Reset with three outstanding flushes tags; next grant is port 0.
        req = 3'b111;
        idle(3);
        req = '0;
        do_reset();
        req = 3'b111;
        cyc();
        req = '0;
        mig_rd_valid = 1'b1;
        mig_rd_data  = rnd_word();
        cyc();
        mig_rd_valid = 1'b0;
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req          = N'($urandom);
            req_adr      = {$urandom, $urandom, $urandom};
            mig_rdy      = ($urandom % 4) != 0;
            mig_rd_valid = (m_q.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 50) == 0);
            mig_rd_data  = rnd_word();
            cyc();
        end
        req          = '0;
        mig_rd_valid = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
